// File: rtl/aes_pkg.sv
// Shared AES helpers: field constants, FSM state encoding and GF(2^8) multiply
// built purely from xtime chains, reusable by both MixColumns directions.
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_COMPUTE = 2'd1;
   localparam state_t ST_DONE    = 2'd2;

   function automatic logic [7:0] gf_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Walk the constant's bits, accumulating successive xtime powers of b
   function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] c);
      logic [7:0] acc;
      logic [7:0] pw;
      acc = 8'h00;
      pw  = b;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) acc = acc ^ pw;
         pw = gf_xtime(pw);
      end
      return acc;
   endfunction

endpackage

// File: rtl/inv_mixcolumn_module_if.sv
// Request/result bundle between a requester (master) and the InvMixColumns block (slave).
interface inv_mixcolumn_module_if;
   logic        start;
   logic [31:0] statew1;
   logic [31:0] statew2;
   logic [31:0] statew3;
   logic [31:0] statew4;
   logic        done;
   logic        busy;
   logic [31:0] new_statew1;
   logic [31:0] new_statew2;
   logic [31:0] new_statew3;
   logic [31:0] new_statew4;

   modport master (
      output start, statew1, statew2, statew3, statew4,
      input  done, busy, new_statew1, new_statew2, new_statew3, new_statew4
   );

   modport slave (
      input  start, statew1, statew2, statew3, statew4,
      output done, busy, new_statew1, new_statew2, new_statew3, new_statew4
   );
endinterface

// File: rtl/inv_mixcolumn_column.sv
// Combinational InvMixColumns of a single column; byte [31:24] is row 0.
module inv_mixcolumn_column
   import aes_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);
   logic [7:0] a0, a1, a2, a3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   // Circulant matrix rows {0e 0b 0d 09} rotated right per output row
   assign col_out[31:24] = gf_mul_const(a0, 8'h0E) ^ gf_mul_const(a1, 8'h0B) ^
                           gf_mul_const(a2, 8'h0D) ^ gf_mul_const(a3, 8'h09);
   assign col_out[23:16] = gf_mul_const(a0, 8'h09) ^ gf_mul_const(a1, 8'h0E) ^
                           gf_mul_const(a2, 8'h0B) ^ gf_mul_const(a3, 8'h0D);
   assign col_out[15:8]  = gf_mul_const(a0, 8'h0D) ^ gf_mul_const(a1, 8'h09) ^
                           gf_mul_const(a2, 8'h0E) ^ gf_mul_const(a3, 8'h0B);
   assign col_out[7:0]   = gf_mul_const(a0, 8'h0B) ^ gf_mul_const(a1, 8'h0D) ^
                           gf_mul_const(a2, 8'h09) ^ gf_mul_const(a3, 8'h0E);
endmodule

// File: rtl/inv_mixcolumn_module.sv
// AES InvMixColumns over a captured 4-column state. Define INV_MIXCOL_FULLPAR_EN
// for four parallel column units (1-cycle compute); default shares one unit over 4 cycles.
module inv_mixcolumn_module
   import aes_pkg::*;
(
   input logic                         clk,
   input logic                         rst_n,
   inv_mixcolumn_module_if.slave       bus
);
   state_t      state;
   logic [1:0]  col_cnt;
   logic [31:0] cap_w   [4];
   logic [31:0] out_w   [4];
   logic [31:0] col_res [4];
   logic        last_col;
   logic        done_r;
   logic        busy_r;

`ifdef INV_MIXCOL_FULLPAR_EN
   for (genvar g = 0; g < 4; g++) begin : g_col
      inv_mixcolumn_column u_col (
         .col_in  (cap_w[g]),
         .col_out (col_res[g])
      );
   end

   assign last_col = 1'b1;
`else
   logic [31:0] shared_res;
   logic [31:0] work_w [3];

   inv_mixcolumn_column u_col (
      .col_in  (cap_w[col_cnt]),
      .col_out (shared_res)
   );

   assign last_col = (col_cnt == 2'd3);

   always_comb begin
      col_res[0] = work_w[0];
      col_res[1] = work_w[1];
      col_res[2] = work_w[2];
      col_res[3] = shared_res;
   end

   // Columns 0..2 park here so the visible outputs only change at completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) work_w[i] <= 32'h0;
      end else if (state == ST_COMPUTE) begin
         case (col_cnt)
            2'd0:    work_w[0] <= shared_res;
            2'd1:    work_w[1] <= shared_res;
            2'd2:    work_w[2] <= shared_res;
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         col_cnt <= 2'd0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cap_w[i] <= 32'h0;
            out_w[i] <= 32'h0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  cap_w   <= '{bus.statew1, bus.statew2, bus.statew3, bus.statew4};
                  col_cnt <= 2'd0;
                  busy_r  <= 1'b1;
                  state   <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               col_cnt <= col_cnt + 2'd1;
               if (last_col) begin
                  out_w  <= col_res;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            // A held start parks here, so a new transform needs start to drop first
            ST_DONE: begin
               if (!bus.start) begin
                  done_r <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.done        = done_r;
   assign bus.busy        = busy_r;
   assign bus.new_statew1 = out_w[0];
   assign bus.new_statew2 = out_w[1];
   assign bus.new_statew3 = out_w[2];
   assign bus.new_statew4 = out_w[3];
endmodule
